soc: RTL and testbench

SOC -- requirements
Module: soc

---
 rtl/soc.sv | 210 +++++++++++++++++++++
 tb/tb_soc.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc.sv
// Single-cycle RV32I system: instruction ROM, core and register file.
// The ROM has no write path; its contents are loaded hierarchically from outside.

module soc_rom #(
    parameter int ROM_DEPTH = 4096
) (
    input  logic [29:0] word_addr_i,
    output logic [31:0] inst_o
);
    localparam int AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;

    logic [31:0] rom_mem [0:ROM_DEPTH-1];

    always_comb begin
        inst_o = 32'h0000_0013;
        if ({2'b00, word_addr_i} < 32'(ROM_DEPTH)) begin
            inst_o = rom_mem[word_addr_i[AW-1:0]];
        end
    end
endmodule

module soc_regs (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic        we_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [31:0] rd_data_i,
    output logic [31:0] rs1_data_o,
    output logic [31:0] rs2_data_o
);
    logic [31:0] regs [0:31];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (we_i && (rd_addr_i != 5'd0)) begin
            regs[rd_addr_i] <= rd_data_i;
        end
    end

    assign rs1_data_o = (rs1_addr_i == 5'd0) ? 32'd0 : regs[rs1_addr_i];
    assign rs2_data_o = (rs2_addr_i == 5'd0) ? 32'd0 : regs[rs2_addr_i];
endmodule

module soc_core #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    output logic [29:0] fetch_addr_o
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    logic [31:0] pc_q, pc_d, pc_plus4;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm_i, imm_b, imm_u, imm_j;
    logic [31:0] rs1_data, rs2_data;
    logic [31:0] alu_b, alu_res;
    logic        alu_sub, alu_sra, br_taken;
    logic        wb_en;
    logic [31:0] wb_data;

    assign opcode   = inst_i[6:0];
    assign rd       = inst_i[11:7];
    assign funct3   = inst_i[14:12];
    assign rs1      = inst_i[19:15];
    assign rs2      = inst_i[24:20];
    assign imm_i    = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_b    = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u    = {inst_i[31:12], 12'd0};
    assign imm_j    = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign pc_plus4 = pc_q + 32'd4;

    // Low PC bits are dropped so misaligned jump targets still fetch a word.
    assign fetch_addr_o = pc_q[31:2];

    soc_regs regs_inst (
        .clk        (clk),
        .rst        (rst),
        .rs1_addr_i (rs1),
        .rs2_addr_i (rs2),
        .we_i       (wb_en),
        .rd_addr_i  (rd),
        .rd_data_i  (wb_data),
        .rs1_data_o (rs1_data),
        .rs2_data_o (rs2_data)
    );

    // inst[30] selects SUB only for register ops; for immediates it is an imm bit.
    assign alu_b   = (opcode == OP_REG) ? rs2_data : imm_i;
    assign alu_sub = (opcode == OP_REG) && inst_i[30];
    assign alu_sra = inst_i[30];

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000: alu_res = alu_sub ? (rs1_data - alu_b) : (rs1_data + alu_b);
            3'b001: alu_res = rs1_data << alu_b[4:0];
            3'b010: alu_res = {31'd0, $signed(rs1_data) < $signed(alu_b)};
            3'b011: alu_res = {31'd0, rs1_data < alu_b};
            3'b100: alu_res = rs1_data ^ alu_b;
            3'b101: begin
                if (alu_sra) begin
                    alu_res = $signed(rs1_data) >>> alu_b[4:0];
                end else begin
                    alu_res = rs1_data >> alu_b[4:0];
                end
            end
            3'b110: alu_res = rs1_data | alu_b;
            default: alu_res = rs1_data & alu_b;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000: br_taken = (rs1_data == rs2_data);
            3'b001: br_taken = (rs1_data != rs2_data);
            3'b100: br_taken = ($signed(rs1_data) < $signed(rs2_data));
            3'b101: br_taken = !($signed(rs1_data) < $signed(rs2_data));
            3'b110: br_taken = (rs1_data < rs2_data);
            3'b111: br_taken = !(rs1_data < rs2_data);
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        pc_d    = pc_plus4;
        wb_en   = 1'b0;
        wb_data = '0;
        case (opcode)
            OP_LUI: begin
                wb_en   = 1'b1;
                wb_data = imm_u;
            end
            OP_AUIPC: begin
                wb_en   = 1'b1;
                wb_data = pc_q + imm_u;
            end
            OP_JAL: begin
                wb_en   = 1'b1;
                wb_data = pc_plus4;
                pc_d    = pc_q + imm_j;
            end
            OP_JALR: begin
                if (funct3 == 3'b000) begin
                    wb_en   = 1'b1;
                    wb_data = pc_plus4;
                    pc_d    = (rs1_data + imm_i) & 32'hFFFF_FFFE;
                end
            end
            OP_BRANCH: begin
                if (br_taken) begin
                    pc_d = pc_q + imm_b;
                end
            end
            OP_IMM, OP_REG: begin
                wb_en   = 1'b1;
                wb_data = alu_res;
            end
            default: begin
                pc_d = pc_plus4;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end
endmodule

module soc #(
    parameter int          ROM_DEPTH = 4096,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input logic clk,
    input logic rst
);
    logic [29:0] fetch_addr;
    logic [31:0] inst;

    soc_rom #(.ROM_DEPTH(ROM_DEPTH)) rom_inst (
        .word_addr_i (fetch_addr),
        .inst_o      (inst)
    );

    soc_core #(.RESET_PC(RESET_PC)) riscv_inst (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst),
        .fetch_addr_o (fetch_addr)
    );
endmodule

// File: tb/tb_soc.sv
// Bench for soc: directed programs and random programs compared every cycle
// against an instruction-level model of RV32I.

module tb_soc;
    localparam int          RD  = 256;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [31:0] prog [$];
    logic [31:0] m_rom [0:RD-1];
    logic [31:0] m_x   [0:31];
    logic [31:0] m_pc;

    soc #(.ROM_DEPTH(RD), .RESET_PC(32'h0000_0000)) dut (
        .clk (clk),
        .rst (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm[11:0], rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] off, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3);
        return {off[12], off[10:5], rs2, rs1, f3, off[4:1], off[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input logic [31:0] off, input logic [4:0] rd);
        return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'd0;
        for (int i = 0; i < 32; i++) m_x[i] = 32'd0;
    endtask

    // One instruction, written directly from the ISA rules.
    task automatic model_step();
        logic [31:0] in, a, b, immi, immb, immj, res, nxt;
        logic [4:0]  rd, sh;
        logic [2:0]  f3;
        logic        wr;
        in   = ((m_pc >> 2) < RD) ? m_rom[m_pc >> 2] : NOP;
        rd   = in[11:7];
        f3   = in[14:12];
        a    = m_x[in[19:15]];
        b    = m_x[in[24:20]];
        immi = {{20{in[31]}}, in[31:20]};
        immb = {{20{in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
        immj = {{12{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
        nxt  = m_pc + 4;
        wr   = 1'b0;
        res  = 32'd0;
        case (in[6:0])
            7'h37: begin wr = 1'b1; res = {in[31:12], 12'd0}; end
            7'h17: begin wr = 1'b1; res = m_pc + {in[31:12], 12'd0}; end
            7'h6F: begin wr = 1'b1; res = m_pc + 4; nxt = m_pc + immj; end
            7'h67: if (f3 == 3'd0) begin
                wr = 1'b1; res = m_pc + 4; nxt = (a + immi) & ~32'd1;
            end
            7'h63: begin
                logic t;
                case (f3)
                    3'd0: t = (a == b);
                    3'd1: t = (a != b);
                    3'd4: t = int'(a) < int'(b);
                    3'd5: t = int'(a) >= int'(b);
                    3'd6: t = a < b;
                    3'd7: t = a >= b;
                    default: t = 1'b0;
                endcase
                if (t) nxt = m_pc + immb;
            end
            7'h13, 7'h33: begin
                logic isreg;
                isreg = (in[6:0] == 7'h33);
                if (!isreg) b = immi;
                sh = b[4:0];
                wr = 1'b1;
                case (f3)
                    3'd0: res = (isreg && in[30]) ? a - b : a + b;
                    3'd1: res = a << sh;
                    3'd2: res = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                    3'd3: res = (a < b) ? 32'd1 : 32'd0;
                    3'd4: res = a ^ b;
                    3'd5: res = (a >> sh) | ((in[30] && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                    3'd6: res = a | b;
                    default: res = a & b;
                endcase
            end
            default: ;
        endcase
        if (wr && rd != 5'd0) m_x[rd] = res;
        m_pc = nxt;
    endtask

    task automatic compare_state(input string tag);
        check({tag, " pc"}, dut.riscv_inst.pc_q, m_pc);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s x%0d", tag, i), dut.riscv_inst.regs_inst.regs[i], m_x[i]);
        end
    endtask

    task automatic load_and_reset(input string tag);
        rst = 1'b1;
        for (int i = 0; i < RD; i++) begin
            m_rom[i] = (i < prog.size()) ? prog[i] : NOP;
            dut.rom_inst.rom_mem[i] = m_rom[i];
        end
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        check({tag, " reset pc"}, dut.riscv_inst.pc_q, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("%s reset x%0d", tag, i), dut.riscv_inst.regs_inst.regs[i], 32'd0);
        end
    endtask

    task automatic run(input string tag, input int n);
        for (int c = 0; c < n; c++) begin
            tick();
            model_step();
            compare_state(tag);
        end
    endtask

    task automatic gen_random(input int n);
        logic [31:0] w;
        logic [31:0] off;
        logic [4:0]  rd, r1, r2;
        logic [2:0]  f3;
        prog.delete();
        for (int k = 0; k < n; k++) begin
            rd  = 5'($urandom_range(0, 11));
            r1  = 5'($urandom_range(0, 11));
            r2  = 5'($urandom_range(0, 11));
            f3  = 3'($urandom_range(0, 7));
            off = 32'((int'($urandom_range(0, 10)) - 4) * 4);
            case ($urandom_range(0, 12))
                0: w = {$urandom_range(0, 20'hFFFFF) % 32'h100000, 12'd0} | {20'd0, rd, 7'h37};
                1: w = {20'($urandom), rd, 7'h17};
                2: w = enc_j(off, rd);
                3: w = enc_i(32'($urandom_range(0, n) * 4 + $urandom_range(0, 1)),
                             ($urandom_range(0, 3) == 0) ? r1 : 5'd0, 3'd0, rd, 7'h67);
                4: w = enc_b(off, r2, r1, ($urandom_range(0, 1) == 1) ? {1'b1, f3[1:0]} : {2'b00, f3[0]});
                5, 6, 7: begin
                    if (f3 == 3'd1)      w = enc_i({27'd0, r2}, r1, f3, rd, 7'h13);
                    else if (f3 == 3'd5) w = enc_i({20'd0, $urandom_range(0, 1) == 1 ? 7'h20 : 7'h00, r2}, r1, f3, rd, 7'h13);
                    else                 w = enc_i($urandom, r1, f3, rd, 7'h13);
                end
                8, 9, 10: w = enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                                    r2, r1, f3, rd);
                11: begin
                    w = $urandom;
                    case ($urandom_range(0, 3))
                        0: w[6:0] = 7'h03;
                        1: w[6:0] = 7'h23;
                        2: w[6:0] = 7'h0F;
                        default: w[6:0] = 7'h73;
                    endcase
                end
                default: begin w = $urandom; w[6:0] = 7'h7F; end
            endcase
            prog.push_back(w);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;

        prog = {enc_i(5, 0, 0, 1, 7'h13), enc_i(-3, 0, 0, 2, 7'h13),
                enc_r(7'h00, 2, 1, 0, 3), enc_r(7'h20, 2, 1, 0, 4)};
        load_and_reset("arith");
        run("arith", 4);
        check("arith x3", dut.riscv_inst.regs_inst.regs[3], 32'd2);
        check("arith x4", dut.riscv_inst.regs_inst.regs[4], 32'd8);
        $display("program arith: checks=%0d errors=%0d", checks, errors);

        prog = {enc_i(9, 0, 0, 5, 7'h13), enc_i(7, 0, 0, 0, 7'h13), enc_r(7'h00, 0, 0, 0, 5)};
        load_and_reset("x0");
        run("x0", 3);
        check("x0 x0", dut.riscv_inst.regs_inst.regs[0], 32'd0);
        check("x0 x5", dut.riscv_inst.regs_inst.regs[5], 32'd0);
        $display("program x0: checks=%0d errors=%0d", checks, errors);

        prog = {enc_i(-1, 0, 0, 1, 7'h13), enc_i(3, 0, 0, 7, 7'h13),
                enc_r(7'h00, 1, 0, 3, 6), enc_r(7'h00, 1, 0, 2, 7),
                enc_i(32'h404, 1, 5, 8, 7'h13), enc_i(28, 1, 5, 9, 7'h13)};
        load_and_reset("cmp");
        run("cmp", 6);
        check("cmp sltu x6", dut.riscv_inst.regs_inst.regs[6], 32'd1);
        check("cmp slt x7", dut.riscv_inst.regs_inst.regs[7], 32'd0);
        check("cmp srai x8", dut.riscv_inst.regs_inst.regs[8], 32'hFFFF_FFFF);
        check("cmp srli x9", dut.riscv_inst.regs_inst.regs[9], 32'h0000_000F);
        $display("program cmp: checks=%0d errors=%0d", checks, errors);

        prog = {NOP, NOP, NOP, NOP, enc_j(8, 1), enc_i(1, 0, 0, 10, 7'h13),
                enc_b(16, 0, 0, 3'd1), enc_i(2, 0, 0, 11, 7'h13)};
        load_and_reset("jump");
        run("jump", 5);
        check("jump link x1", dut.riscv_inst.regs_inst.regs[1], 32'h14);
        check("jump target pc", dut.riscv_inst.pc_q, 32'h18);
        run("jump", 2);
        check("bne not taken pc", dut.riscv_inst.pc_q, 32'h20);
        check("jump skipped x10", dut.riscv_inst.regs_inst.regs[10], 32'd0);
        check("bne fallthrough x11", dut.riscv_inst.regs_inst.regs[11], 32'd2);
        $display("program jump: checks=%0d errors=%0d", checks, errors);

        for (int t = 0; t < 4; t++) begin
            gen_random(48);
            load_and_reset($sformatf("rand%0d", t));
            run($sformatf("rand%0d", t), 80);
            $display("program rand%0d: checks=%0d errors=%0d", t, checks, errors);
        end

        gen_random(48);
        load_and_reset("midrst");
        run("midrst", 20);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst pc", dut.riscv_inst.pc_q, 32'd0);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("midrst x%0d", i), dut.riscv_inst.regs_inst.regs[i], 32'd0);
        end
        model_reset();
        run("rerun", 60);
        $display("program midrst: checks=%0d errors=%0d", checks, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
